// File: rtl/pipe_tx_symbol_packer_if.sv
// Handshake and bus bundle for pipe_tx_symbol_packer.
// Optional statistics signals exist only when PIPE_TX_PACK_STATS_EN is defined.
interface pipe_tx_symbol_packer_if #(
  parameter int MAX_BYTES  = 4,
  parameter int FIFO_DEPTH = 8
);
  logic [1:0]                    width;
  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          in_k;
  logic                          in_ready;
  logic                          flush;
  logic                          tx_en;
  logic [8*MAX_BYTES-1:0]        tx_data;
  logic [MAX_BYTES-1:0]          tx_data_k;
  logic                          tx_data_valid;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic                          width_pending;
`ifdef PIPE_TX_PACK_STATS_EN
  logic [31:0]                   sym_count;
  logic [15:0]                   pad_count;

  modport master (
    output width, in_valid, in_data, in_k, flush, tx_en,
    input  in_ready, tx_data, tx_data_k, tx_data_valid, level, width_pending,
           sym_count, pad_count
  );

  modport slave (
    input  width, in_valid, in_data, in_k, flush, tx_en,
    output in_ready, tx_data, tx_data_k, tx_data_valid, level, width_pending,
           sym_count, pad_count
  );
`else
  modport master (
    output width, in_valid, in_data, in_k, flush, tx_en,
    input  in_ready, tx_data, tx_data_k, tx_data_valid, level, width_pending
  );

  modport slave (
    input  width, in_valid, in_data, in_k, flush, tx_en,
    output in_ready, tx_data, tx_data_k, tx_data_valid, level, width_pending
  );
`endif
endinterface

// File: rtl/pipe_tx_symbol_packer.sv
// Byte-serial symbol stream -> PIPE tx_data/tx_data_k packer with runtime width.
// Optional byte/pad statistics counters: define PIPE_TX_PACK_STATS_EN.
//
// state | meaning
// RUN   | accept bytes, emit full words
// FLUSH | input blocked, drain full words, pad and emit the last partial word
module pipe_tx_symbol_packer #(
  parameter int         MAX_BYTES  = 4,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] PAD_SYMBOL = 8'hF7
) (
  input logic                    clk,
  input logic                    reset,
  pipe_tx_symbol_packer_if.slave bus
);
  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam int         LW       = AW + 1;
  localparam logic [1:0] MAX_CODE = 2'($clog2(MAX_BYTES));

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             width_q, width_d;
  logic [LW-1:0]          level_q, level_d;
  logic [LW-1:0]          n_bytes, pop_cnt;
  logic [AW-1:0]          wr_q, rd_q, rd_idx;
  logic [8:0]             mem_q [FIFO_DEPTH];
  logic                   push, full_pop, pad_pop, emit, in_ready;
  logic [8*MAX_BYTES-1:0] tx_data_q, tx_data_d;
  logic [MAX_BYTES-1:0]   tx_k_q, tx_k_d;
  logic                   valid_q;

  // Handshake, pop decision, next state and the packed output word.
  always_comb begin
    state_d   = state_q;
    width_d   = (bus.width > MAX_CODE) ? MAX_CODE : bus.width;
    n_bytes   = LW'(1) << width_q;
    in_ready  = (level_q < LW'(FIFO_DEPTH)) && (state_q == RUN);
    push      = bus.in_valid && in_ready;
    full_pop  = bus.tx_en && (level_q >= n_bytes);
    pad_pop   = (state_q == FLUSH) && bus.tx_en && (level_q != '0) && (level_q < n_bytes);
    emit      = full_pop || pad_pop;
    pop_cnt   = full_pop ? n_bytes : (pad_pop ? level_q : '0);
    level_d   = level_q + LW'(push) - pop_cnt;
    tx_data_d = '0;
    tx_k_d    = '0;
    rd_idx    = rd_q;
    for (int i = 0; i < MAX_BYTES; i++) begin
      rd_idx = rd_q + AW'(i);
      if (LW'(i) < n_bytes) begin
        if (LW'(i) < level_q) begin
          tx_data_d[8*i +: 8] = mem_q[rd_idx][7:0];
          tx_k_d[i]           = mem_q[rd_idx][8];
        end else begin
          tx_data_d[8*i +: 8] = PAD_SYMBOL;
          tx_k_d[i]           = 1'b1;
        end
      end
    end
    case (state_q)
      RUN:     if (bus.flush) state_d = FLUSH;
      FLUSH:   if (level_q == '0 || pad_pop) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Byte storage; contents need no reset since level/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.in_k, bus.in_data};
  end

  // Control state, pointers, level, active width and output word registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      width_q   <= width_d;
      level_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      tx_data_q <= '0;
      tx_k_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && level_q == '0) width_q <= width_d;
      level_q <= level_d;
      if (push) wr_q <= wr_q + AW'(1);
      rd_q    <= rd_q + AW'(pop_cnt);
      valid_q <= emit;
      if (emit) begin
        tx_data_q <= tx_data_d;
        tx_k_q    <= tx_k_d;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_k     = tx_k_q;
  assign bus.tx_data_valid = valid_q;
  assign bus.level         = level_q;
  assign bus.width_pending = (width_d != width_q);

`ifdef PIPE_TX_PACK_STATS_EN
  logic [31:0]   sym_q;
  logic [15:0]   pad_q;
  logic [LW-1:0] pad_bytes;
  logic [32:0]   sym_sum;
  logic [16:0]   pad_sum;

  // Saturating sums of real bytes popped and pad bytes inserted.
  always_comb begin
    pad_bytes = pad_pop ? (n_bytes - level_q) : '0;
    sym_sum   = {1'b0, sym_q} + 33'(pop_cnt);
    pad_sum   = {1'b0, pad_q} + 17'(pad_bytes);
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sym_q <= '0;
      pad_q <= '0;
    end else begin
      sym_q <= sym_sum[32] ? '1 : sym_sum[31:0];
      pad_q <= pad_sum[16] ? '1 : pad_sum[15:0];
    end
  end

  assign bus.sym_count = sym_q;
  assign bus.pad_count = pad_q;
`endif
endmodule

// File: tb/tb_pipe_tx_symbol_packer.sv
// Directed self-checking bench for pipe_tx_symbol_packer (MAX_BYTES=4, FIFO_DEPTH=8).
module tb_pipe_tx_symbol_packer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  pipe_tx_symbol_packer_if #(.MAX_BYTES(4), .FIFO_DEPTH(8)) bus ();

  pipe_tx_symbol_packer #(.MAX_BYTES(4), .FIFO_DEPTH(8), .PAD_SYMBOL(8'hF7)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic k);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_k     = k;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    bus.width = 2'd2;
    reset = 1'b0;
    tick();
    tick();
    checks++; if (bus.tx_data !== 32'h0) begin failures++; $display("FAIL reset_tx_data got=%h exp=%h", bus.tx_data, 32'h0); end
    checks++; if (bus.tx_data_k !== 4'h0) begin failures++; $display("FAIL reset_tx_data_k got=%b exp=%b", bus.tx_data_k, 4'h0); end
    checks++; if (bus.tx_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.tx_data_valid); end
    checks++; if (bus.level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.width_pending !== 1'b0) begin failures++; $display("FAIL reset_width_pending got=%b exp=0", bus.width_pending); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_word;
    bus.width = 2'd2;
    bus.tx_en = 1'b1;
    push_byte(8'h1C, 1'b1);
    push_byte(8'hBC, 1'b1);
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    checks++; if (bus.tx_data_valid !== 1'b0) begin failures++; $display("FAIL basic_no_early_valid got=%b exp=0", bus.tx_data_valid); end
    checks++; if (bus.level !== 4'd4) begin failures++; $display("FAIL basic_level4 got=%0d exp=4", bus.level); end
    tick();
    checks++; if (bus.tx_data !== 32'h0201BC1C) begin failures++; $display("FAIL basic_data got=%h exp=%h", bus.tx_data, 32'h0201BC1C); end
    checks++; if (bus.tx_data_k !== 4'b0011) begin failures++; $display("FAIL basic_k got=%b exp=%b", bus.tx_data_k, 4'b0011); end
    checks++; if (bus.tx_data_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.tx_data_valid); end
    checks++; if (bus.level !== 4'd0) begin failures++; $display("FAIL basic_level0 got=%0d exp=0", bus.level); end
    tick();
    checks++; if (bus.tx_data_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%b exp=0", bus.tx_data_valid); end
    checks++; if (bus.tx_data !== 32'h0201BC1C) begin failures++; $display("FAIL basic_data_hold got=%h exp=%h", bus.tx_data, 32'h0201BC1C); end
    bus.tx_en = 1'b0;
  endtask

  task automatic test_flush;
    bus.width = 2'd1;
    bus.tx_en = 1'b0;
    do_reset();
    push_byte(8'hAA, 1'b0);
    push_byte(8'hBB, 1'b0);
    push_byte(8'hCC, 1'b0);
    push_byte(8'hDD, 1'b0);
    push_byte(8'hEE, 1'b0);
    checks++; if (bus.level !== 4'd5) begin failures++; $display("FAIL flush_level5 got=%0d exp=5", bus.level); end
    bus.flush = 1'b1;
    bus.tx_en = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    #1;
    checks++; if (bus.tx_data !== 32'h0000BBAA) begin failures++; $display("FAIL flush_word0 got=%h exp=%h", bus.tx_data, 32'h0000BBAA); end
    checks++; if (bus.level !== 4'd3) begin failures++; $display("FAIL flush_level3 got=%0d exp=3", bus.level); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready0 got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.tx_data !== 32'h0000DDCC) begin failures++; $display("FAIL flush_word1 got=%h exp=%h", bus.tx_data, 32'h0000DDCC); end
    checks++; if (bus.level !== 4'd1) begin failures++; $display("FAIL flush_level1 got=%0d exp=1", bus.level); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready1 got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.tx_data !== 32'h0000F7EE) begin failures++; $display("FAIL flush_pad_word got=%h exp=%h", bus.tx_data, 32'h0000F7EE); end
    checks++; if (bus.tx_data_k !== 4'b0010) begin failures++; $display("FAIL flush_pad_k got=%b exp=%b", bus.tx_data_k, 4'b0010); end
    checks++; if (bus.tx_data_valid !== 1'b1) begin failures++; $display("FAIL flush_pad_valid got=%b exp=1", bus.tx_data_valid); end
    checks++; if (bus.level !== 4'd0) begin failures++; $display("FAIL flush_level0 got=%0d exp=0", bus.level); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready_back got=%b exp=1", bus.in_ready); end
`ifdef PIPE_TX_PACK_STATS_EN
    checks++; if (bus.sym_count !== 32'd5) begin failures++; $display("FAIL stats_sym got=%0d exp=5", bus.sym_count); end
    checks++; if (bus.pad_count !== 16'd1) begin failures++; $display("FAIL stats_pad got=%0d exp=1", bus.pad_count); end
`endif
    tick();
    checks++; if (bus.tx_data_valid !== 1'b0) begin failures++; $display("FAIL flush_after_valid got=%b exp=0", bus.tx_data_valid); end
    bus.tx_en = 1'b0;
  endtask

  task automatic test_full_fifo;
    bus.width = 2'd2;
    bus.tx_en = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b0);
    checks++; if (bus.level !== 4'd8) begin failures++; $display("FAIL full_level8 got=%0d exp=8", bus.level); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    push_byte(8'h18, 1'b0);
    checks++; if (bus.level !== 4'd8) begin failures++; $display("FAIL full_no_overwrite_level got=%0d exp=8", bus.level); end
    checks++; if (bus.tx_data_valid !== 1'b0) begin failures++; $display("FAIL full_valid_low got=%b exp=0", bus.tx_data_valid); end
    bus.tx_en = 1'b1;
    tick();
    checks++; if (bus.tx_data !== 32'h13121110) begin failures++; $display("FAIL full_word0 got=%h exp=%h", bus.tx_data, 32'h13121110); end
    checks++; if (bus.level !== 4'd4) begin failures++; $display("FAIL full_level4 got=%0d exp=4", bus.level); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready_back got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.tx_data !== 32'h17161514) begin failures++; $display("FAIL full_word1 got=%h exp=%h", bus.tx_data, 32'h17161514); end
    checks++; if (bus.level !== 4'd0) begin failures++; $display("FAIL full_level0 got=%0d exp=0", bus.level); end
    bus.tx_en = 1'b0;
  endtask

  task automatic test_width_change;
    bus.width = 2'd0;
    bus.tx_en = 1'b0;
    do_reset();
    push_byte(8'h31, 1'b0);
    push_byte(8'h32, 1'b0);
    push_byte(8'h33, 1'b0);
    bus.width = 2'd2;
    #1;
    checks++; if (bus.width_pending !== 1'b1) begin failures++; $display("FAIL wchg_pending got=%b exp=1", bus.width_pending); end
    bus.tx_en = 1'b1;
    tick();
    checks++; if (bus.tx_data !== 32'h00000031) begin failures++; $display("FAIL wchg_byte0 got=%h exp=%h", bus.tx_data, 32'h31); end
    checks++; if (bus.level !== 4'd2) begin failures++; $display("FAIL wchg_level2 got=%0d exp=2", bus.level); end
    tick();
    checks++; if (bus.tx_data !== 32'h00000032) begin failures++; $display("FAIL wchg_byte1 got=%h exp=%h", bus.tx_data, 32'h32); end
    tick();
    checks++; if (bus.tx_data !== 32'h00000033) begin failures++; $display("FAIL wchg_byte2 got=%h exp=%h", bus.tx_data, 32'h33); end
    checks++; if (bus.width_pending !== 1'b1) begin failures++; $display("FAIL wchg_still_pending got=%b exp=1", bus.width_pending); end
    tick();
    checks++; if (bus.width_pending !== 1'b0) begin failures++; $display("FAIL wchg_applied got=%b exp=0", bus.width_pending); end
    checks++; if (bus.tx_data_valid !== 1'b0) begin failures++; $display("FAIL wchg_idle_valid got=%b exp=0", bus.tx_data_valid); end
    bus.tx_en = 1'b0;
  endtask

  task automatic test_clamp_and_reset;
    bus.width = 2'd3;
    bus.tx_en = 1'b0;
    do_reset();
    checks++; if (bus.width_pending !== 1'b0) begin failures++; $display("FAIL clamp_pending got=%b exp=0", bus.width_pending); end
    for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i), 1'b0);
    bus.tx_en = 1'b1;
    tick();
    checks++; if (bus.tx_data !== 32'h44434241) begin failures++; $display("FAIL clamp_word got=%h exp=%h", bus.tx_data, 32'h44434241); end
    checks++; if (bus.level !== 4'd1) begin failures++; $display("FAIL clamp_level1 got=%0d exp=1", bus.level); end
    bus.tx_en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h46 + 8'(i), 1'b0);
    checks++; if (bus.level !== 4'd5) begin failures++; $display("FAIL midrst_level5 got=%0d exp=5", bus.level); end
    bus.tx_en = 1'b1;
    reset = 1'b0;
    tick();
    checks++; if (bus.level !== 4'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", bus.level); end
    checks++; if (bus.tx_data !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h exp=%h", bus.tx_data, 32'h0); end
    checks++; if (bus.tx_data_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.tx_data_valid); end
    reset = 1'b1;
    bus.tx_en = 1'b0;
    tick();
  endtask

  initial begin
    bus.width    = 2'd2;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_k     = 1'b0;
    bus.flush    = 1'b0;
    bus.tx_en    = 1'b0;
    test_reset();
    test_basic_word();
    test_flush();
    test_full_fifo();
    test_width_change();
    test_clamp_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_tx_symbol_packer.md
Name: pipe_tx_symbol_packer

Overview:
- Parametrised successor to the fixed-width PIPE TX path.
- Accepts a byte-serial symbol stream (data plus K flag) over a valid/ready handshake and buffers it in a byte FIFO.
- Packs the buffered bytes into the PIPE tx_data/tx_data_k bus. The bus width is selected at runtime (8/16/32/64 bits).
- Sits between the MAC-side sequence driver and the PIPE interface TX signals. Supports throttling through tx_en and a flush that pads partial words.

Parameters:
- MAX_BYTES, 4, maximum bytes per PIPE word (1, 2, 4 or 8); tx_data width = 8*MAX_BYTES.
- FIFO_DEPTH, 8, byte FIFO depth; power of 2; must be >= 2*MAX_BYTES.
- PAD_SYMBOL, 8'hF7, pad byte used on flush (K23.7); always emitted with K=1.

Ports:
- clk  in  1  PIPE clock; sole clock.
- reset  in  1  synchronous, active-low reset.
- width  in  2  requested PIPE width: 0=8b, 1=16b, 2=32b, 3=64b.
- in_valid  in  1  input symbol valid.
- in_data  in  8  input symbol byte.
- in_k  in  1  input symbol is a K character.
- in_ready  out  1  packer can accept a symbol.
- flush  in  1  single-cycle request to drain all bytes, padding the last partial word.
- tx_en  in  1  PIPE side may take a word this cycle.
- tx_data  out  8*MAX_BYTES  packed PIPE data; byte 0 in bits [7:0].
- tx_data_k  out  MAX_BYTES  per-byte K flags.
- tx_data_valid  out  1  tx_data/tx_data_k hold a new word.
- level  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- width_pending  out  1  requested width differs from active width.

Behaviour:
- Reset (reset==0 at posedge):
  - tx_data=0, tx_data_k=0, tx_data_valid=0, level=0.
  - State=RUN, FIFO pointers=0.
  - width_q loads the width input, clamped.
- Width clamp: N = 1<<width_q. If 1<<width exceeds MAX_BYTES, N=MAX_BYTES.
- Width change:
  - width_q reloads from width only when state==RUN and level==0.
  - width_pending = (clamped width != width_q); combinational.
- in_ready = (level < FIFO_DEPTH) and state==RUN. Based on pre-edge level only. A simultaneous pop does not raise in_ready in the same cycle.
- Push occurs when in_valid && in_ready.
- Pop/emit, evaluated on pre-edge state:
  - If tx_en && level >= N: pop N bytes, load output lane i (i<N) from fifo[rd+i], set lanes >= N to 0 with K=0, and set tx_data_valid=1.
  - Otherwise tx_data_valid=0. tx_data/tx_data_k hold their last value.
- Latency: a byte pushed at edge t can be emitted at edge t+1 at the earliest.
- Level update: level_next = level + push - popped_bytes. Pointers wrap modulo FIFO_DEPTH.
- States:
  - RUN: flush → FLUSH.
  - FLUSH:
    - in_ready=0. Full words drain as normal.
    - When 0 < level < N and tx_en: emit the remaining bytes in the low lanes, pad lanes up to N-1 with PAD_SYMBOL (K=1), set level to 0, go to RUN.
    - When level==0: go to RUN without emitting.
- flush while already in FLUSH: ignored.
- flush at level==0: one FLUSH cycle, no word emitted.
- Push and flush in the same cycle: the push is accepted (in_ready was 1), then the byte is included in the drain.
- Reset mid-operation: all buffered bytes are discarded; outputs return to reset values on the next edge.
- FIFO full with in_valid held: in_ready=0, no overwrite, no data loss.

Optional Feature:
- Macro: PIPE_TX_PACK_STATS_EN.
- Defined:
  - Adds output sym_count[31:0]: increments by the number of real bytes popped.
  - Adds output pad_count[15:0]: increments by the number of PAD bytes emitted.
  - Both counters are cleared by reset and saturate at all-ones.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- MAX_BYTES=4, width=2, tx_en=1; push 8'h1C(K),8'hBC(K),8'h01,8'h02 on consecutive cycles → at the edge after the 4th push: tx_data=32'h0201BC1C, tx_data_k=4'b0011, tx_data_valid=1 for one cycle; level=0.
- width=1; push 5 bytes AA,BB,CC,DD,EE then pulse flush → words 16'hBBAA, 16'hDDCC, then 16'hF7EE with tx_data_k=2'b10; in_ready=0 until state returns to RUN.
- tx_en=0 while pushing 9 bytes at FIFO_DEPTH=8 → in_ready drops after 8 accepted bytes, level=8, tx_data_valid stays 0. Raise tx_en at width=2 → two words of 4 bytes; in_ready returns 1 the cycle after the first pop.
- width changed 0→2 with level=3 → width_pending=1 and emits continue byte-wide until level=0. width_q=2 on the following edge, then width_pending=0.
- width=3 with MAX_BYTES=4 → N clamped to 4; emitted words are 4 bytes. Assert reset mid-stream with level=5 → next edge: level=0, tx_data=0, tx_data_valid=0.
- With PIPE_TX_PACK_STATS_EN: the flush scenario (5 bytes, width=1) → sym_count=5, pad_count=1.
